// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback pipeline register of the 64-bit RISC-V core.
// It extracts and sign- or zero-extends the load data from the doubleword read
// word, then selects between that and the ALU result. It registers the
// register-file write port and counts retired (valid) instructions.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_valid             real instruction at MEM (0 = bubble)
//   i_stall             hold all stage state this cycle
//   i_flush             capture a bubble instead of the incoming instruction
//   i_regWrite          instruction writes rd
//   i_memToReg          1 = write back load data, 0 = ALU result
//   i_rd_addr[4:0]      destination register
//   i_funct3[2:0]       load type (used only when i_memToReg = 1)
//   i_alu_result        ALU result, or the load effective address
//   i_mem_rdata         doubleword-aligned memory read data
//   o_valid             WB stage holds a real instruction
//   o_regWrite          register-file write enable (never 1 for x0)
//   o_rd_addr[4:0]      register-file write address
//   o_rd_data           register-file write data
//   o_retired           count of valid instructions captured into WB
module mem_wb_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_regWrite,
  input  logic              i_memToReg,
  input  logic [4:0]        i_rd_addr,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_valid,
  output logic              o_regWrite,
  output logic [4:0]        o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]  o_retired
);

  logic [2:0]        off;
  logic [DATA_W-1:0] byte_sh;
  logic [DATA_W-1:0] half_sh;
  logic [DATA_W-1:0] word_sh;
  logic [DATA_W-1:0] load_data;

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic [4:0]        rd_addr_q,  rd_addr_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic [CNT_W-1:0]  retired_q,  retired_d;

  assign off = i_alu_result[2:0];

  // Lane shifts: offset bits below the access size are dropped, so a
  // misaligned access simply reads the naturally aligned lane containing it.
  always_comb begin
    byte_sh = i_mem_rdata >> {off, 3'b000};
    half_sh = i_mem_rdata >> {off[2:1], 4'b0000};
    word_sh = i_mem_rdata >> {off[2], 5'b00000};
  end

  always_comb begin
    load_data = i_mem_rdata;
    unique case (i_funct3)
      3'b000:  load_data = {{(DATA_W-8){byte_sh[7]}},   byte_sh[7:0]};
      3'b001:  load_data = {{(DATA_W-16){half_sh[15]}}, half_sh[15:0]};
      3'b010:  load_data = {{(DATA_W-32){word_sh[31]}}, word_sh[31:0]};
      3'b100:  load_data = {{(DATA_W-8){1'b0}},         byte_sh[7:0]};
      3'b101:  load_data = {{(DATA_W-16){1'b0}},        half_sh[15:0]};
      3'b110:  load_data = {{(DATA_W-32){1'b0}},        word_sh[31:0]};
      default: load_data = i_mem_rdata;
    endcase
  end

  // Flush beats stall. Data and address hold on flush, since they are unused
  // when the stage holds a bubble.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    retired_d  = retired_q;
    if (i_flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!i_stall) begin
      valid_d    = i_valid;
      regwrite_d = i_valid & i_regWrite & (i_rd_addr != 5'd0);
      rd_addr_d  = i_rd_addr;
      rd_data_d  = i_memToReg ? load_data : i_alu_result;
      if (i_valid) retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      retired_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      retired_q  <= retired_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_regWrite = regwrite_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_data  = rd_data_q;
  assign o_retired  = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        regw = 1'b0, m2r = 1'b0;
  logic [4:0]  rd = '0;
  logic [2:0]  f3 = '0;
  logic [63:0] alu = '0, rdata = '0;

  logic        o_valid, o_regw, o4_valid, o4_regw;
  logic [4:0]  o_rd, o4_rd;
  logic [63:0] o_data, o4_data;
  logic [31:0] o_ret;
  logic [3:0]  o4_ret;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // reference state
  logic        m_valid, m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  longint unsigned m_ret;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(64), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
    .i_flush(flush), .i_regWrite(regw), .i_memToReg(m2r), .i_rd_addr(rd),
    .i_funct3(f3), .i_alu_result(alu), .i_mem_rdata(rdata),
    .o_valid(o_valid), .o_regWrite(o_regw), .o_rd_addr(o_rd),
    .o_rd_data(o_data), .o_retired(o_ret)
  );

  mem_wb_stage #(.DATA_W(64), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
    .i_flush(flush), .i_regWrite(regw), .i_memToReg(m2r), .i_rd_addr(rd),
    .i_funct3(f3), .i_alu_result(alu), .i_mem_rdata(rdata),
    .o_valid(o4_valid), .o_regWrite(o4_regw), .o_rd_addr(o4_rd),
    .o_rd_data(o4_data), .o_retired(o4_ret)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load result from access size and signedness, using plain arithmetic.
  function automatic logic [63:0] ref_load(input logic [2:0] t, input logic [63:0] addr,
                                           input logic [63:0] w);
    longint unsigned nbytes, lane, v, bits;
    nbytes = (t == 3'b111) ? 8 : (64'd1 << t[1:0]);
    lane = (addr % 8) - ((addr % 8) % nbytes);
    v = w >> (lane * 8);
    bits = nbytes * 8;
    if (nbytes < 8) begin
      v = v % (64'd1 << bits);
      if (!t[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_rd = 0; m_data = 0; m_ret = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_valid = 0; m_we = 0;
    end else if (!stall) begin
      m_valid = valid;
      m_we = valid && regw && (rd != 0);
      m_rd = rd;
      m_data = m2r ? ref_load(f3, alu, rdata) : alu;
      if (valid) m_ret = m_ret + 1;
    end
  endtask

  task automatic check_all();
    check("valid", {63'd0, o_valid}, {63'd0, m_valid});
    check("regWrite", {63'd0, o_regw}, {63'd0, m_we});
    check("retired", {32'd0, o_ret}, m_ret % (64'd1 << 32));
    check("retired4", {60'd0, o4_ret}, m_ret % 16);
    if (m_valid) begin
      check("rd_addr", {59'd0, o_rd}, {59'd0, m_rd});
      check("rd_data", o_data, m_data);
      check("rd_data4", o4_data, m_data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic s, input logic fl, input logic w,
                       input logic mr, input logic [4:0] r, input logic [2:0] t,
                       input logic [63:0] a, input logic [63:0] d);
    valid = v; stall = s; flush = fl; regw = w; m2r = mr; rd = r; f3 = t;
    alu = a; rdata = d;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_regWrite", {63'd0, o_regw}, 64'd0);
    check("rst_rd_addr", {59'd0, o_rd}, 64'd0);
    check("rst_rd_data", o_data, 64'd0);
    check("rst_retired", {32'd0, o_ret}, 64'd0);
    check("rst_retired4", {60'd0, o4_ret}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [63:0] W = 64'h8877_6655_F4F3_F281;
  logic [2:0]  ext_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b110, 3'b011};
  logic [63:0] ext_a   [5] = '{64'd0, 64'd0, 64'd2, 64'd4, 64'd0};
  logic [63:0] ext_exp [5] = '{64'hFFFF_FFFF_FFFF_FF81, 64'h81,
                               64'hFFFF_FFFF_FFFF_F4F3, 64'h8877_6655, W};

  longint unsigned saved;

  initial begin
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // ALU writes, then reset between edges mid-stream
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 1, 0, 5'(i), 0, 64'(i * 64'h1111), 0);
      step();
    end
    do_reset();

    // load extraction
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 1, 5'd5, ext_f3[i], ext_a[i], W);
      step();
      check($sformatf("ext%0d", i), o_data, ext_exp[i]);
    end

    // ALU result to x0
    saved = m_ret;
    drive(1, 0, 0, 1, 0, 5'd0, 0, 64'd123, 0);
    step();
    check("x0_regWrite", {63'd0, o_regw}, 64'd0);
    check("x0_retired", {32'd0, o_ret}, saved + 1);

    // stall hold
    drive(1, 0, 0, 1, 0, 5'd7, 0, 64'hAA, 0);
    step();
    saved = m_ret;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 0, 5'($urandom_range(31)), 0, {$urandom, $urandom}, 0);
      step();
      check("stall_rd", {59'd0, o_rd}, 64'd7);
      check("stall_data", o_data, 64'hAA);
      check("stall_ret", {32'd0, o_ret}, saved);
    end

    // flush beats stall
    drive(1, 1, 1, 1, 0, 5'd9, 0, 64'h55, 0);
    step();
    check("flush_valid", {63'd0, o_valid}, 64'd0);
    check("flush_regWrite", {63'd0, o_regw}, 64'd0);
    check("flush_ret", {32'd0, o_ret}, saved);

    // 4-bit counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 0, 0, 5'd1, 0, 64'(i), 0);
      step();
    end
    check("wrap4", {60'd0, o4_ret}, 64'd1);
    check("wrap32", {32'd0, o_ret}, 64'd17);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
            $urandom_range(1) == 1, $urandom_range(1) == 1, 5'($urandom_range(31)),
            3'($urandom_range(7)), {$urandom, $urandom}, {$urandom, $urandom});
      step();
      if (o_regw) check("x0_never", {63'd0, o_rd == 5'd0}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/writeback pipeline stage of the 64-bit RISC-V pipeline. It registers the MEM-stage result, extracts and sign/zero-extends load data from the 64-bit memory read word, and selects between ALU result and load data. It drives the register file's write port (`rd_addr`, `rd_data`, `regWrite`), which the register file also forwards combinationally to its read ports. It also counts retired instructions.

## Interface
Parameters:
- `DATA_W`, default 64: datapath width. Only 64 is supported.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_valid`  in  1  a real instruction is present at the MEM stage (0 = bubble).
- `i_stall`  in  1  hold all stage state this cycle.
- `i_flush`  in  1  replace the incoming instruction with a bubble.
- `i_regWrite`  in  1  the instruction writes `rd`.
- `i_memToReg`  in  1  1 = write-back source is load data; 0 = ALU result.
- `i_rd_addr`  in  5  destination register.
- `i_funct3`  in  3  load type; used only when `i_memToReg`=1.
- `i_alu_result`  in  DATA_W  ALU result, or the load's effective address.
- `i_mem_rdata`  in  DATA_W  doubleword-aligned memory read data.
- `o_valid`  out  1  the WB stage holds a real instruction.
- `o_regWrite`  out  1  register-file write enable.
- `o_rd_addr`  out  5  register-file write address.
- `o_rd_data`  out  DATA_W  register-file write data.
- `o_retired`  out  CNT_W  count of valid instructions captured into WB.

## Operation
Write-back data is computed combinationally from the inputs and captured into the WB register.

Byte offset:
- `off = i_alu_result[2:0]`.
- Bits below the access size are ignored.
- No misalignment trap is raised.

Load selection by `i_funct3` (data taken from `i_mem_rdata`):
- 000 lb: byte at `off*8`, sign-extended.
- 001 lh: halfword at `off[2:1]*16`, sign-extended.
- 010 lw: word at `off[2]*32`, sign-extended.
- 011 ld: the full 64-bit word.
- 100 lbu: byte at `off*8`, zero-extended.
- 101 lhu: halfword at `off[2:1]*16`, zero-extended.
- 110 lwu: word at `off[2]*32`, zero-extended.
- 111: treated as ld.

Write-back data: load result when `i_memToReg`=1, otherwise `i_alu_result`.

Capture priority at each rising edge, highest first:
- `i_flush`=1: capture a bubble. `o_valid`=0 and `o_regWrite`=0; data and address registers are don't-care and hold their old value. Flush wins over stall.
- `i_stall`=1: all WB registers and the counter hold.
- Otherwise: capture the inputs. The stored write enable is `i_valid & i_regWrite & (i_rd_addr != 0)`.

Retire counter:
- Increments by 1 on every non-flushed, non-stalled edge where `i_valid`=1.
- Increments whether or not the instruction writes a register.
- Wraps modulo 2^CNT_W.

Outputs are driven directly from registers. There is no combinational path from any input to any output.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N, and the register file writes them at edge N+1.
- During a stall the outputs stay constant. A held `o_regWrite`=1 rewrites the same value, which is idempotent and intended.
- Reset, asserted at any time including mid-stall: immediately forces `o_valid`=0, `o_regWrite`=0, `o_rd_addr`=0, `o_rd_data`=0 and `o_retired`=0. The first capture occurs on the first rising edge after deassertion.
- `o_regWrite` is never 1 when `o_rd_addr`=0.
- Back-to-back valid instructions are accepted every cycle with no bubbles inserted.

## Test plan
- Reset mid-stream: drive valid ALU writes, then assert `i_rst_n`=0 between edges. Expect all outputs 0 immediately and `o_retired`=0.
- Sign and zero extension: set `i_mem_rdata`=0x8877_6655_F4F3_F281, `i_memToReg`=1, rd=5.
  - lb, off=0 -> 0xFFFF_FFFF_FFFF_FF81.
  - lbu, off=0 -> 0x81.
  - lh, off=2 -> 0xFFFF_FFFF_FFFF_F4F3.
  - lwu, off=4 -> 0x8877_6655.
  - ld -> the full word.
- ALU path and x0: `i_memToReg`=0, `i_alu_result`=123, rd=0, `i_regWrite`=1. Expect `o_regWrite`=0 and `o_retired` incremented by 1.
- Stall hold: capture rd=7, data=0xAA, then assert `i_stall` for 3 cycles while the inputs change. Expect the outputs held at rd=7/0xAA and the counter unchanged.
- Flush vs stall: assert `i_flush`=1 and `i_stall`=1 together with valid inputs. Expect `o_valid`=0, `o_regWrite`=0 next cycle, and no counter increment.
- Counter wrap (CNT_W=4): 17 valid instructions -> `o_retired`=1.
